// File: rtl/relu_share_sched.sv
// -----------------------------------------------------------------------------
// relu_share_sched
//   Round-robin scheduler sharing one registered ReLU unit (1-cycle latency, no
//   stall input) among NUM_REQ conv-output lanes. A lane is granted for a burst
//   that ends on its last word or after BURST_MAX beats. Accepted words go to
//   the ReLU, and the lane id/last sideband rides a 1-stage tag pipe. The two
//   are rejoined and pushed into a 2-entry output FIFO. Issue is gated by FIFO
//   credits, so a word handed to the ReLU always has a slot waiting for it.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/data/last     per-lane request stream (lane i data at [i*DW +: DW])
//   req_ready               per-lane accept, one-hot or zero
//   act_enable/act_data_in  drive the shared ReLU
//   act_valid/act_data_out  ReLU result, one cycle after act_enable
//   out_valid/data/id/last  result stream, head of the output FIFO
//   out_ready               downstream accept
//
// Optional build macro RELU_SCHED_PERF_EN adds saturating counters:
//   perf_busy_cyc  (cycles with act_enable=1)
//   perf_stall_cyc (BURST cycles with the granted lane valid but no credit)
//   perf_bursts    (completed bursts)
// -----------------------------------------------------------------------------
module relu_share_sched #(
   parameter int NUM_REQ    = 4,
   parameter int INT_BITS   = 16,
   parameter int FRAC_BITS  = 16,
   parameter int DATA_WIDTH = INT_BITS + FRAC_BITS,
   parameter int BURST_MAX  = 16,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          act_enable,
   output logic [DATA_WIDTH-1:0]         act_data_in,
   input  logic                          act_valid,
   input  logic [DATA_WIDTH-1:0]         act_data_out,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_W-1:0]               out_id,
   output logic                          out_last,
   input  logic                          out_ready
`ifdef RELU_SCHED_PERF_EN
   ,
   output logic [31:0]                   perf_busy_cyc,
   output logic [31:0]                   perf_stall_cyc,
   output logic [15:0]                   perf_bursts
`endif
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);

   typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

   state_t                r_state, w_state_nxt;
   logic [ID_W-1:0]       r_rr, w_rr_nxt;
   logic [ID_W-1:0]       r_grant, w_grant_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [ID_W-1:0]       w_pick;
   logic                  w_found;
   int                    w_idx;
   logic                  w_pop, w_push, w_credit, w_accept, w_end;
   logic [DATA_WIDTH-1:0] w_lane_word;
   logic                  w_lane_last;

   logic                  r_tag_vld, r_tag_last;
   logic [ID_W-1:0]       r_tag_id;

   logic [1:0]            r_occ;
   logic                  r_wp, r_rp;
   logic [DATA_WIDTH-1:0] r_buf_data [2];
   logic [ID_W-1:0]       r_buf_id   [2];
   logic                  r_buf_last [2];

   // First requesting lane at or above the rr pointer, wrapping.
   always_comb begin
      w_pick  = r_rr;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = int'(r_rr) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = ID_W'(w_idx);
         end
      end
   end

   assign w_lane_word = req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
   assign w_lane_last = req_last[r_grant];

   // Credit = 2 - occupancy - in-flight, plus the slot a same-cycle pop frees.
   assign out_valid = (r_occ != 2'd0);
   assign w_pop     = out_valid & out_ready;
   assign w_push    = act_valid & r_tag_vld;  // stale ReLU output after reset is ignored
   assign w_credit  = ({1'b0, r_occ} + {2'b00, r_tag_vld}) < (3'd2 + {2'b00, w_pop});

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_rr_nxt    = r_rr;
      w_cnt_nxt   = r_cnt;
      req_ready   = '0;
      w_accept    = 1'b0;
      w_end       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant_nxt = w_pick;
               w_state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            req_ready[r_grant] = w_credit;
            w_accept           = req_valid[r_grant] & w_credit;
            if (w_accept) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (w_lane_last || (r_cnt == CNT_W'(BURST_MAX - 1))) begin
                  w_end       = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_IDLE;
                  w_rr_nxt    = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + ID_W'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign act_enable  = w_accept;
   assign act_data_in = w_accept ? w_lane_word : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rr       <= '0;
         r_grant    <= '0;
         r_cnt      <= '0;
         r_tag_vld  <= 1'b0;
         r_tag_id   <= '0;
         r_tag_last <= 1'b0;
         r_occ      <= 2'd0;
         r_wp       <= 1'b0;
         r_rp       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr       <= w_rr_nxt;
         r_grant    <= w_grant_nxt;
         r_cnt      <= w_cnt_nxt;
         // Tag pipe stage: sideband of the word now inside the ReLU
         r_tag_vld  <= w_accept;
         r_tag_id   <= r_grant;
         r_tag_last <= w_lane_last;
         // Output FIFO stage
         r_occ      <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
         if (w_push) r_wp <= ~r_wp;
         if (w_pop)  r_rp <= ~r_rp;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf_data[r_wp] <= act_data_out;
         r_buf_id[r_wp]   <= r_tag_id;
         r_buf_last[r_wp] <= r_tag_last;
      end
   end

   // Storage is not reset, so the head is masked while the FIFO is empty.
   assign out_data = out_valid ? r_buf_data[r_rp] : '0;
   assign out_id   = out_valid ? r_buf_id[r_rp]   : '0;
   assign out_last = out_valid ? r_buf_last[r_rp] : 1'b0;

   a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (w_push && !w_pop) |-> (r_occ != 2'd2));

`ifdef RELU_SCHED_PERF_EN
   logic w_stall;
   assign w_stall = (r_state == S_BURST) && req_valid[r_grant] && !w_credit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_cyc  <= '0;
         perf_stall_cyc <= '0;
         perf_bursts    <= '0;
      end else begin
         if (w_accept && (perf_busy_cyc != '1))  perf_busy_cyc  <= perf_busy_cyc + 32'd1;
         if (w_stall && (perf_stall_cyc != '1))  perf_stall_cyc <= perf_stall_cyc + 32'd1;
         if (w_end && (perf_bursts != '1))       perf_bursts    <= perf_bursts + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_relu_share_sched.sv
// -----------------------------------------------------------------------------
// tb_relu_share_sched
//   Bench for relu_share_sched. Models the shared ReLU as a registered unit
//   (negative -> 0, positive clamped at +32767.0), feeds per-lane source queues
//   and keeps a per-lane expected queue filled at stimulus time. A monitor pops
//   the queue of out_id on every handshake and checks burst non-interleaving.
// -----------------------------------------------------------------------------
module tb_relu_share_sched;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int BM = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic [N-1:0]      req_last = '0;
   logic [N-1:0]      req_ready;
   logic              act_enable;
   logic [DW-1:0]     act_data_in;
   logic              act_valid = 1'b0;
   logic [DW-1:0]     act_data_out = '0;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_id;
   logic              out_last;
   logic              out_ready = 1'b1;
`ifdef RELU_SCHED_PERF_EN
   logic [31:0]       perf_busy_cyc;
   logic [31:0]       perf_stall_cyc;
   logic [15:0]       perf_bursts;
`endif

   relu_share_sched #(.NUM_REQ(N), .INT_BITS(16), .FRAC_BITS(16), .BURST_MAX(BM)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .act_enable(act_enable), .act_data_in(act_data_in),
      .act_valid(act_valid), .act_data_out(act_data_out),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last),
      .out_ready(out_ready)
`ifdef RELU_SCHED_PERF_EN
      , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc), .perf_bursts(perf_bursts)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
      if (x[DW-1])               return '0;
      if (x > 32'h7FFF_0000)     return 32'h7FFF_0000;
      return x;
   endfunction

   // Stand-in for the shared ReLU: registered, fixed 1-cycle latency.
   always @(posedge clk) begin
      act_valid    <= act_enable;
      act_data_out <= relu_ref(act_data_in);
   end

   beat_t src_q [N][$];
   beat_t exp_q [N][$];
   int    acc_lane[$], acc_cyc[$];
   int    out_id_log[$], out_cyc_log[$];
   logic [DW-1:0] out_dat_log[$];
   int    acc_total = 0, n_out = 0, onehot_err = 0;
   logic [N-1:0] lane_en = '0;
   int    ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
   int    valid_pct = 100;
   int    tests = 0, fails = 0;
   logic  mb_act = 1'b0;
   int    mb_id = 0, mb_cnt = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
      end
   endfunction

   task automatic add_word(input int lane, input logic [DW-1:0] d, input logic l);
      src_q[lane].push_back('{d: d, l: l});
      exp_q[lane].push_back('{d: relu_ref(d), l: l});
   endtask

   // Driver: new inputs each negedge, accepts recorded once combinational ready settles.
   initial begin : driver
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (lane_en[i] && src_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
               req_valid[i]         = 1'b1;
               req_data[i*DW +: DW] = src_q[i][0].d;
               req_last[i]          = src_q[i][0].l;
            end else begin
               req_valid[i]         = 1'b0;
               req_data[i*DW +: DW] = $urandom;
               req_last[i]          = 1'($urandom_range(1));
            end
         end
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1));
         endcase
         #1;
         if ($countones(req_ready) > 1) onehot_err++;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               void'(src_q[i].pop_front());
               acc_lane.push_back(i);
               acc_cyc.push_back(cyc);
               acc_total++;
            end
         end
      end
   end

   // Monitor: checks each delivered word against the lane's expected queue.
   initial begin : monitor
      beat_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid && out_ready) begin
            n_out++;
            out_id_log.push_back(int'(out_id));
            out_cyc_log.push_back(cyc);
            out_dat_log.push_back(out_data);
            if (exp_q[out_id].size() == 0) begin
               chk("out_unexpected_word", 64'd1, 64'd0);
            end else begin
               e = exp_q[out_id].pop_front();
               chk("out_data", out_data, e.d);
               chk("out_last", out_last, e.l);
            end
            if (mb_act) chk("burst_no_interleave", out_id, mb_id);
            if (mb_act && int'(out_id) == mb_id) mb_cnt++;
            else begin
               mb_id  = int'(out_id);
               mb_cnt = 1;
            end
            mb_act = !(out_last || mb_cnt == BM);
         end
      end
   end

   task automatic rst_assert();
      rst_n = 1'b0;
      lane_en = '0;
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      acc_lane.delete(); acc_cyc.delete();
      out_id_log.delete(); out_cyc_log.delete(); out_dat_log.delete();
      acc_total = 0; n_out = 0; mb_act = 1'b0;
   endtask

   task automatic rst_release();
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_assert();
      repeat (2) @(posedge clk);
      #1;
      rst_release();
   endtask

   task automatic wait_out(input int n, input int lim, input string nm);
      int c = 0;
      while (n_out < n && c < lim) begin
         @(posedge clk);
         c++;
      end
      chk(nm, n_out, n);
   endtask

   task automatic wait_acc(input int n, input int lim, input string nm);
      int c = 0;
      while (acc_total < n && c < lim) begin
         @(posedge clk);
         c++;
      end
      chk(nm, acc_total, n);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int total;
      ready_mode = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_act", {act_enable, act_data_in}, 0);
      chk("rst_out", {out_valid, out_last, out_id, out_data}, 0);
      rst_release();

      // Single lane, literal vectors
      add_word(0, 32'h0001_8000, 1'b0);
      add_word(0, 32'hFFFF_0000, 1'b0);
      add_word(0, 32'h7FFF_FFFF, 1'b1);
      lane_en = 4'b0001;
      wait_out(3, 50, "t1_count");
      if (out_dat_log.size() == 3) begin
         chk("t1_w0", out_dat_log[0], 32'h0001_8000);
         chk("t1_w1", out_dat_log[1], 32'h0000_0000);
         chk("t1_w2", out_dat_log[2], 32'h7FFF_0000);
         chk("t1_latency", out_cyc_log[0] - acc_cyc[0], 2);
      end

      // Round-robin, 2-word bursts from all lanes
      do_reset();
      for (int i = 0; i < N; i++) begin
         add_word(i, $urandom, 1'b0);
         add_word(i, $urandom, 1'b1);
      end
      lane_en = 4'b1111;
      wait_out(8, 100, "t2_count");
      if (n_out == 8) begin
         for (int k = 0; k < 8; k++) chk("t2_rr_id", out_id_log[k], k / 2);
         for (int k = 1; k < 8; k++) chk("t2_rr_gap", acc_cyc[k] - acc_cyc[0], k + k / 2);
      end
`ifdef RELU_SCHED_PERF_EN
      chk("perf_busy", perf_busy_cyc, 8);
      chk("perf_bursts", perf_bursts, 4);
      chk("perf_stall", perf_stall_cyc, 0);
`endif

      // BURST_MAX forced re-arbitration
      do_reset();
      for (int k = 0; k < 20; k++) add_word(2, $urandom, 1'b0);
      add_word(1, $urandom, 1'b0);
      add_word(1, $urandom, 1'b1);
      lane_en = 4'b0100;
      wait_acc(1, 20, "t3_first_acc");
      lane_en = 4'b0110;
      wait_out(22, 200, "t3_count");
      if (n_out == 22) begin
         for (int k = 0; k < 22; k++)
            chk("t3_id_seq", out_id_log[k], (k >= 16 && k < 18) ? 1 : 2);
      end

      // Back-pressure: downstream stalled for 10 cycles
      do_reset();
      ready_mode = 0;
      for (int k = 0; k < 8; k++) add_word(3, $urandom, k == 7);
      lane_en = 4'b1000;
      repeat (10) @(posedge clk);
      #1;
      chk("t4_acc_count", acc_total, 2);
      chk("t4_ready_low", req_ready, 0);
      chk("t4_out_valid", out_valid, 1);
      ready_mode = 1;
      wait_out(8, 100, "t4_count");
      chk("t4_src_empty", src_q[3].size(), 0);

      // Reset with one word buffered and one in the ReLU
      do_reset();
      add_word(2, $urandom, 1'b1);
      lane_en = 4'b0100;
      wait_out(1, 30, "t5_prep");
      ready_mode = 0;
      for (int k = 0; k < 4; k++) add_word(3, $urandom, 1'b0);
      lane_en = 4'b1000;
      wait_acc(3, 30, "t5_acc");
      #1;
      chk("t5_pre_buffered", out_valid, 1);
      chk("t5_pre_inflight", act_valid, 1);
      rst_assert();
      #1;
      chk("t5_rst_outs", {req_ready, act_enable, act_data_in, out_valid, out_last, out_id, out_data}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_release();
      ready_mode = 1;
      repeat (5) @(posedge clk);
      #1;
      chk("t5_no_stale_out", n_out, 0);
      chk("t5_idle_valid", out_valid, 0);
      add_word(1, $urandom, 1'b1);
      add_word(3, $urandom, 1'b1);
      lane_en = 4'b1010;
      wait_out(2, 40, "t5_count");
      if (n_out == 2) chk("t5_rr_from_zero", out_id_log[0], 1);

      // Randomized traffic with random back-pressure
      do_reset();
      total = 0;
      for (int i = 0; i < N; i++) begin
         int nw;
         nw = 20 + $urandom_range(30);
         for (int k = 0; k < nw; k++) begin
            logic [DW-1:0] d;
            d = $urandom;
            if ($urandom_range(3) == 0) d = {1'b0, d[30:0]} | 32'h7FFF_0000;
            add_word(i, d, (k == nw - 1) || ($urandom_range(5) == 0));
         end
         total += nw;
      end
      valid_pct  = 70;
      ready_mode = 2;
      lane_en    = 4'b1111;
      wait_out(total, 8000, "t6_count");
      for (int i = 0; i < N; i++) chk("t6_exp_drained", exp_q[i].size(), 0);
      chk("ready_onehot", onehot_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
